// File: rtl/sop_eval_pkg.sv
// ============================================================================
// Module : sop_eval_pkg
// Desc   : Shared types, sizing functions and parameter legality checks for
//          the programmable sum-of-products evaluation unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sop_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERR    = 2'd3
    } cfg_state_e;

    function automatic int tbl_bits(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int words(input int n_in, input int cfg_w);
        return tbl_bits(n_in) / cfg_w;
    endfunction

    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic bit params_ok(input int n_in, input int n_ch, input int cfg_w);
        return (n_in >= 2) && (n_in <= 8) && (n_ch >= 1) && (n_ch <= 8) &&
               (cfg_w > 0) && ((tbl_bits(n_in) % cfg_w) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sop_eval_cfg_loader.sv
// ============================================================================
// Module : sop_eval_cfg_loader
// Desc   : Truth-table load FSM: collects config beats into a shadow table and
//          issues a one-cycle commit strobe, or aborts on a malformed load.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sop_eval_cfg_loader
    import sop_eval_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int N_CH  = 2,
    parameter int CFG_W = 8,
    parameter int TBL   = tbl_bits(N_IN),
    parameter int CH_W  = ch_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_last,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             commit,
    output logic [CH_W-1:0]  commit_ch,
    output logic [TBL-1:0]   shadow
);

    localparam int WORDS = words(N_IN, CFG_W);
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    cfg_state_e       state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [TBL-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    ch_d                 = cfg_ch;
                    shadow_d[CFG_W-1:0]  = cfg_data;
                    count_d              = CNT_W'(1);
                    if (int'(cfg_ch) >= N_CH)
                        state_d = ST_ERR;
                    else if (WORDS == 1)
                        state_d = cfg_last ? ST_COMMIT : ST_ERR;
                    else
                        state_d = cfg_last ? ST_ERR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cfg_valid) begin
                    shadow_d[count_q*CFG_W +: CFG_W] = cfg_data;
                    count_d = count_q + 1'b1;
                    // The final word must coincide with cfg_last, anything else aborts
                    if (count_q == LAST_WORD)
                        state_d = cfg_last ? ST_COMMIT : ST_ERR;
                    else
                        state_d = cfg_last ? ST_ERR : ST_LOAD;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_ERR: begin
                state_d  = ST_IDLE;
                shadow_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        done_d  = (state_d == ST_COMMIT);
        err_d   = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            shadow_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign commit    = done_q;
    assign commit_ch = ch_q;
    assign shadow    = shadow_q;

endmodule

`default_nettype wire

// File: rtl/sop_eval_unit.sv
// ============================================================================
// Module : sop_eval_unit
// Desc   : N_CH run-time programmable N_IN-input Boolean functions, two-cycle
//          evaluation pipeline. Optional hit counter: SOP_EVAL_HITCNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sop_eval_unit
    import sop_eval_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int N_CH  = 2,
    parameter int CFG_W = 8,
    parameter int TBL   = tbl_bits(N_IN),
    parameter int CH_W  = ch_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    output logic [N_CH-1:0]  out_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_last,
    output logic             cfg_done,
    output logic             cfg_err
`ifdef SOP_EVAL_HITCNT_EN
    ,
    output logic [15:0]      hit_cnt
`endif
);

    if (!params_ok(N_IN, N_CH, CFG_W)) begin : g_bad_params
        $error("sop_eval_unit: illegal N_IN/N_CH/CFG_W combination");
    end

    logic            commit;
    logic [CH_W-1:0] commit_ch;
    logic [TBL-1:0]  shadow;

    sop_eval_cfg_loader #(
        .N_IN  (N_IN),
        .N_CH  (N_CH),
        .CFG_W (CFG_W)
    ) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .commit    (commit),
        .commit_ch (commit_ch),
        .shadow    (shadow)
    );

    logic [N_CH-1:0][TBL-1:0] active_q, active_d;
    logic                     s1_valid_q, s1_valid_d;
    logic [N_IN-1:0]          s1_idx_q, s1_idx_d;
    logic                     out_valid_q, out_valid_d;
    logic [N_CH-1:0]          out_data_q, out_data_d;

    // Stage 2 reads active_q, so a lookup on the commit edge still sees the old table
    always_comb begin
        active_d    = active_q;
        s1_valid_d  = in_valid;
        s1_idx_d    = in_data;
        out_valid_d = s1_valid_q;
        out_data_d  = '0;
        for (int k = 0; k < N_CH; k++) begin
            out_data_d[k] = active_q[k][s1_idx_q];
            if (commit && (int'(commit_ch) == k))
                active_d[k] = shadow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            active_q    <= active_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SOP_EVAL_HITCNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (commit && (commit_ch == '0))
            hit_cnt_d = '0;
        else if (out_valid_q && out_data_q[0] && (hit_cnt_q != 16'hFFFF))
            hit_cnt_d = hit_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit_cnt_q <= '0;
        else
            hit_cnt_q <= hit_cnt_d;
    end

    assign hit_cnt = hit_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sop_eval_unit.sv
// ============================================================================
// Module : tb_sop_eval_unit
// Desc   : Directed self-checking bench with an expected-result scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sop_eval_unit;

    localparam int N_IN  = 5;
    localparam int N_CH  = 2;
    localparam int CFG_W = 8;
    localparam int WORDS = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [N_IN-1:0]  in_data;
    logic             out_valid;
    logic [N_CH-1:0]  out_data;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [0:0]       cfg_ch;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_last;
    logic             cfg_done;
    logic             cfg_err;
`ifdef SOP_EVAL_HITCNT_EN
    logic [15:0]      hit_cnt;
`endif

    sop_eval_unit #(.N_IN(N_IN), .N_CH(N_CH), .CFG_W(CFG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
`ifdef SOP_EVAL_HITCNT_EN
        ,
        .hit_cnt   (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N_IN-1:0] idx;
        int              stamp;
    } ev_t;
    ev_t sb_q[$];

    // Reference tables: old_tbl applies to lookup edges before eff_cyc, new_tbl from it on
    logic [31:0] old_tbl [N_CH];
    logic [31:0] new_tbl [N_CH];
    int          eff_cyc [N_CH];
    bit          stream_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_CH-1:0] exp_out(input logic [N_IN-1:0] idx);
        logic [N_CH-1:0] r;
        logic [31:0]     t;
        for (int k = 0; k < N_CH; k++) begin
            t    = (cyc >= eff_cyc[k]) ? new_tbl[k] : old_tbl[k];
            r[k] = t[idx];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            old_tbl[k] = '0;
            new_tbl[k] = '0;
            eff_cyc[k] = 0;
        end
    endtask

    // Commit seen during cycle d: the table loads on edge d+1, first new lookup on edge d+2
    task automatic model_commit(input int ch, input logic [31:0] tbl);
        old_tbl[ch] = (cyc >= eff_cyc[ch]) ? new_tbl[ch] : old_tbl[ch];
        new_tbl[ch] = tbl;
        eff_cyc[ch] = cyc + 2;
    endtask

    task automatic push_ev(input logic [N_IN-1:0] idx);
        ev_t e;
        e.idx   = idx;
        e.stamp = cyc;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stream_on) begin
            in_valid = 1'b1;
            in_data  = '0;
            push_ev('0);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic eval(input logic [N_IN-1:0] idx);
        in_valid = 1'b1;
        in_data  = idx;
        push_ev(idx);
        tick();
    endtask

    // outcome: 0 = none expected yet (partial load), 1 = commit, 2 = abort
    task automatic do_load(input int ch, input logic [31:0] tbl, input int nbeats,
                           input int last_idx, input int outcome);
        for (int b = 0; b < nbeats; b++) begin
            chk("cfg_ready_beat", 32'(cfg_ready), 32'd1);
            cfg_valid = 1'b1;
            cfg_ch    = 1'(ch);
            cfg_data  = tbl[b*CFG_W +: CFG_W];
            cfg_last  = (b == last_idx);
            tick();
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        if (outcome != 0) begin
            chk("cfg_done_pulse", 32'(cfg_done), (outcome == 1) ? 32'd1 : 32'd0);
            chk("cfg_err_pulse", 32'(cfg_err), (outcome == 2) ? 32'd1 : 32'd0);
            chk("cfg_ready_busy", 32'(cfg_ready), 32'd0);
            if (outcome == 1)
                model_commit(ch, tbl);
            tick();
            chk("cfg_done_clear", 32'(cfg_done), 32'd0);
            chk("cfg_err_clear", 32'(cfg_err), 32'd0);
            chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("out_valid_spurious", 32'(out_valid), 32'd0);
                end else begin
                    ev_t e;
                    e = sb_q.pop_front();
                    chk("latency", 32'(cyc), 32'(e.stamp + 2));
                    chk("out_data", 32'(out_data), 32'(exp_out(e.idx)));
                end
            end else if (sb_q.size() > 0 && sb_q[0].stamp + 2 <= cyc) begin
                void'(sb_q.pop_front());
                chk("out_valid_missing", 32'(out_valid), 32'd1);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        model_reset();

        // Reset defaults
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst_n = 1'b1;
        tick();
        eval(5'h1F);
        repeat (3) tick();
        chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);

        // Valid load of ch0: bits 0 and 31 set
        do_load(0, 32'h8000_0001, WORDS, WORDS - 1, 1);
        chk("model_ch0", new_tbl[0], 32'h8000_0001);
        eval(5'd0);
        eval(5'd31);
        eval(5'd7);
        eval(5'd16);
        repeat (3) tick();

        // Early cfg_last on beat 2 of a ch1 load
        do_load(1, 32'hFFFF_FFFF, 2, 1, 2);
        eval(5'd0);
        eval(5'd31);
        repeat (3) tick();

        // Concurrent eval stream across a ch1 commit
        stream_on = 1'b1;
        tick();
        do_load(1, 32'hFFFF_FFFF, WORDS, WORDS - 1, 1);
        repeat (5) tick();
        stream_on = 1'b0;
        repeat (4) tick();

        // Asynchronous reset in the middle of a load and of the pipeline
        do_load(0, 32'h1234_5678, 2, -1, 0);
        in_valid = 1'b1;
        in_data  = 5'd31;
        rst_n    = 1'b0;
        #1;
        sb_q.delete();
        model_reset();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("midrst_cfg_done", 32'(cfg_done), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        tick();
        eval(5'd0);
        eval(5'd31);
        repeat (3) tick();
        do_load(1, 32'hA5C3_0FF0, WORDS, WORDS - 1, 1);
        for (int i = 0; i < 32; i += 3)
            eval(5'(i));
        repeat (4) tick();

`ifdef SOP_EVAL_HITCNT_EN
        do_load(0, 32'hFFFF_FFFF, WORDS, WORDS - 1, 1);
        stream_on = 1'b1;
        repeat (70000) tick();
        stream_on = 1'b0;
        repeat (4) tick();
        chk("hit_cnt_sat", 32'(hit_cnt), 32'h0000_FFFF);
        do_load(0, 32'hFFFF_FFFF, WORDS, WORDS - 1, 1);
        chk("hit_cnt_clear", 32'(hit_cnt), 32'd0);
        repeat (4) tick();
`endif

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sop_eval_unit.md
# sop_eval_unit

Programmable, registered successor to the team's fixed gate-level logic-function blocks. Each of N_CH channels evaluates an arbitrary N_IN-input Boolean function, stored as a truth table of 2^N_IN bits. A table is loaded at run time over a valid/ready configuration port. Evaluation is pipelined with a fixed two-cycle latency. The block sits between input-capture logic and downstream control that previously consumed hard-wired sum-of-products outputs.

## Interface
- N_IN, 5, function input count (2..8)
- N_CH, 2, channel count (1..8)
- CFG_W, 8, config word width; must divide 2^N_IN; WORDS = 2^N_IN / CFG_W
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  evaluation request
- in_data  in  N_IN  function inputs; value used as truth-table bit index
- out_valid  out  1  result valid
- out_data  out  N_CH  bit k = channel k's table bit at the sampled index
- cfg_valid  in  1  config beat offered
- cfg_ready  out  1  config beat accepted when both high
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel, sampled on first beat only
- cfg_data  in  CFG_W  table word; beat k loads bits [k*CFG_W +: CFG_W]
- cfg_last  in  1  final beat of a load
- cfg_done  out  1  one-cycle pulse: table committed
- cfg_err  out  1  one-cycle pulse: load aborted

## Operation
- Reset: all active tables = 0, shadow = 0, FSM = IDLE, out_valid/out_data/cfg_done/cfg_err = 0, cfg_ready = 1.
- Eval path, no backpressure. Stage 1 registers in_valid/in_data. Stage 2 registers out_valid and out_data[k] = active[k][idx].
- Load FSM: IDLE, LOAD, COMMIT, ERR.
  - IDLE, cfg_ready=1. Accepted beat: latch cfg_ch, write shadow word 0, count=1.
  - From IDLE: cfg_ch ≥ N_CH → ERR. Otherwise, with WORDS==1: cfg_last → COMMIT, else → ERR. With WORDS>1: cfg_last → ERR, else → LOAD.
  - LOAD, cfg_ready=1. Accepted beat writes word[count] and increments count.
  - From LOAD: cfg_last with count==WORDS-1 → COMMIT. cfg_last early → ERR. count==WORDS-1 without cfg_last → ERR.
  - COMMIT, cfg_ready=0, 1 cycle: active[ch] ← shadow, cfg_done=1 → IDLE.
  - ERR, cfg_ready=0, 1 cycle: shadow discarded, active tables untouched, cfg_err=1 → IDLE.
- Only the committed channel changes; other channels are unaffected.

## Timing
- Latency: in_valid at edge n → out_valid at edge n+2. Throughput 1 per cycle.
- Table switch is atomic. Stage-2 lookups at the COMMIT edge or earlier use the old table; lookups from the next edge onward use the new table. No mixed old/new bits.
- Load time: WORDS accepted beats, then 1 COMMIT cycle. Minimum 2 cycles from first beat to cfg_done.
- cfg_valid while cfg_ready=0: not accepted; the source holds the beat.
- Evaluation and loading run concurrently with no mutual stall.
- rst_n low mid-load or mid-pipeline: immediate clear to reset values. No partial commit, no pending out_valid.

## Configuration
- SOP_EVAL_HITCNT_EN defined:
  - adds output hit_cnt [15:0], reset 0;
  - increments on each cycle with out_valid && out_data[0];
  - saturates at 16'hFFFF;
  - clears on rst_n and on any commit to channel 0.
- Undefined: no port and no counter logic.

## Structure
- Package sop_eval_pkg holds:
  - FSM state enum (IDLE, LOAD, COMMIT, ERR);
  - localparam functions for table size and WORDS;
  - parameter legality checks for elaboration-time assertion.
- Sub-module sop_eval_cfg_loader holds the FSM, shadow register, word counter and channel latch. It outputs a commit strobe, channel index and shadow table.
- Top holds active tables, eval pipeline and optional counter.

## Test plan
- Reset check, defaults: hold rst_n=0, then release, then in_valid with in_data=5'h1F → out_valid at +2, out_data=2'b00. cfg_ready=1 throughout.
- Valid load: load ch0 with words 8'h01,00,00,80 (WORDS=4) → cfg_done 1 cycle after 4th beat. Then in_data=0 → out_data[0]=1, in_data=31 → 1, in_data=7 → 0.
- Early cfg_last: cfg_last on beat 2 of a ch1 load → cfg_err pulse. ch1 table unchanged, and in_data=0 still gives out_data[1]=0.
- Concurrent eval and commit: stream in_data=0 every cycle while committing an all-ones table to ch1. out_data[1] flips 0→1 exactly on the first lookup after the COMMIT edge, with no gap in out_valid.
- Reset mid-load: deassert then reassert rst_n after beat 2 → no cfg_done. All tables read 0, FSM back in IDLE, next full load succeeds.
- SOP_EVAL_HITCNT_EN: 70000 evals with ch0 all-ones → hit_cnt=16'hFFFF. Recommit ch0 → hit_cnt=0.
